ysyx_24100029_ifu_fetch: RTL and testbench

//  Instruction-fetch stage directly upstream of the decode stage. Holds the PC, issues one
//  32-bit read per instruction on a single-outstanding AXI4-Lite-style read channel, and presents
//  {inst, pc} to decode through a valid_next/ready_next handshake. Accepts redirects (branch,

---
 rtl/ysyx_24100029_ifu_fetch.sv | 135 +++++++++++++
 tb/tb_ysyx_24100029_ifu_fetch.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24100029_ifu_fetch.sv
// Instruction fetch stage: holds the PC, issues single-outstanding reads and hands {inst, pc} to decode.
// Ports: clock/reset, redirect_*, AXI4-Lite-style AR/R read channel, inst/pc/fetch_err with valid_next/ready_next.
module ysyx_24100029_ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter logic [31:0] ERR_INST = 32'h0000_0013
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready,
    output logic [31:0] inst,
    output logic [31:0] pc,
    output logic        fetch_err,
    output logic        valid_next,
    input  logic        ready_next
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_OUT
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_reg_q, pc_reg_d;
    logic [31:0] araddr_q, araddr_d;
    logic        drop_q, drop_d;
    logic        arvalid_q, arvalid_d;
    logic        rready_q, rready_d;
    logic        valid_q, valid_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] pc_q, pc_d;
    logic        err_q, err_d;
    logic [31:0] redir_pc;

    assign redir_pc = redirect_pc & ~32'h3;

    always_comb begin
        state_d  = state_q;
        pc_reg_d = pc_reg_q;
        araddr_d = araddr_q;
        drop_d   = drop_q;
        inst_d   = inst_q;
        pc_d     = pc_q;
        err_d    = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (redirect_valid) pc_reg_d = redir_pc;
                state_d = S_ADDR;
            end
            S_ADDR: begin
                if (redirect_valid) begin
                    pc_reg_d = redir_pc;
                    drop_d   = 1'b1;
                end
                if (arready) state_d = S_DATA;
            end
            S_DATA: begin
                if (redirect_valid) pc_reg_d = redir_pc;
                if (rvalid) begin
                    if (drop_q || redirect_valid) begin
                        drop_d  = 1'b0;
                        state_d = S_ADDR;
                    end else begin
                        inst_d  = (rresp == 2'b00) ? rdata : ERR_INST;
                        pc_d    = pc_reg_q;
                        err_d   = (rresp != 2'b00);
                        state_d = S_OUT;
                    end
                end else if (redirect_valid) begin
                    drop_d = 1'b1;
                end
            end
            S_OUT: begin
                if (redirect_valid) begin
                    pc_reg_d = redir_pc;
                    state_d  = S_ADDR;
                end else if (ready_next) begin
                    pc_reg_d = pc_reg_q + 32'd4;
                    state_d  = S_ADDR;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // The issued address is captured on ADDR entry so a redirect during
        // an outstanding request never disturbs araddr while arvalid is high.
        if (state_d == S_ADDR && state_q != S_ADDR) araddr_d = pc_reg_d;
        arvalid_d = (state_d == S_ADDR);
        rready_d  = (state_d == S_DATA);
        valid_d   = (state_d == S_OUT);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            pc_reg_q  <= RESET_PC;
            araddr_q  <= RESET_PC;
            drop_q    <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            valid_q   <= 1'b0;
            inst_q    <= 32'h0;
            pc_q      <= 32'h0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_reg_q  <= pc_reg_d;
            araddr_q  <= araddr_d;
            drop_q    <= drop_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            valid_q   <= valid_d;
            inst_q    <= inst_d;
            pc_q      <= pc_d;
            err_q     <= err_d;
        end
    end

    assign araddr     = araddr_q;
    assign arvalid    = arvalid_q;
    assign rready     = rready_q;
    assign valid_next = valid_q;
    assign inst       = inst_q;
    assign pc         = pc_q;
    assign fetch_err  = err_q;

endmodule

// File: tb/tb_ysyx_24100029_ifu_fetch.sv
// Bench for ysyx_24100029_ifu_fetch: memory responder, address/output scoreboards, directed steps.
// Ports: drives every DUT port; checks issued addresses and decode-side beats.
module tb_ysyx_24100029_ifu_fetch;

    logic        clock;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        fetch_err;
    logic        valid_next;
    logic        ready_next;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        err;
    } exp_t;

    logic [31:0] exp_addr[$];
    exp_t        exp_out[$];
    int          checks = 0;
    int          errors = 0;
    int          n_out = 0;
    int          ar_delay = 0;
    int          r_delay = 0;
    logic [31:0] err_addr = 32'h8000_0010;

    ysyx_24100029_ifu_fetch dut (
        .clock          (clock),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .araddr         (araddr),
        .arvalid        (arvalid),
        .arready        (arready),
        .rdata          (rdata),
        .rresp          (rresp),
        .rvalid         (rvalid),
        .rready         (rready),
        .inst           (inst),
        .pc             (pc),
        .fetch_err      (fetch_err),
        .valid_next     (valid_next),
        .ready_next     (ready_next)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_out(input logic [31:0] a, input logic e);
        exp_t x;
        x.inst = e ? 32'h0000_0013 : mem_word(a);
        x.pc   = a;
        x.err  = e;
        exp_out.push_back(x);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_valid(input string tag);
        bit ok = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (valid_next) begin
                ok = 1;
                break;
            end
        end
        chk(tag, {31'b0, ok}, 32'd1);
    endtask

    task automatic wait_rready(input string tag);
        bit ok = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (rready) begin
                ok = 1;
                break;
            end
        end
        chk(tag, {31'b0, ok}, 32'd1);
    endtask

    task automatic wait_nout(input int n, input string tag);
        bit ok = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (n_out >= n) begin
                ok = 1;
                break;
            end
        end
        chk(tag, {31'b0, ok}, 32'd1);
    endtask

    // Memory responder: accepts the address after ar_delay cycles,
    // returns data r_delay cycles later, one transaction at a time.
    initial begin
        int          phase;
        int          cnt;
        logic [31:0] a;
        phase = 0;
        cnt = 0;
        a = 32'h0;
        arready = 1'b0;
        rvalid = 1'b0;
        rdata = 32'h0;
        rresp = 2'b00;
        forever begin
            @(negedge clock);
            if (!reset) begin
                arready = 1'b0;
                rvalid = 1'b0;
                phase = 0;
                cnt = 0;
            end else begin
                if (phase == 2) begin
                    rvalid = 1'b0;
                    phase = 0;
                    cnt = 0;
                end
                if (phase == 1) begin
                    arready = 1'b0;
                    if (cnt >= r_delay) begin
                        rvalid = 1'b1;
                        rdata = mem_word(a);
                        rresp = (a == err_addr) ? 2'b10 : 2'b00;
                        phase = 2;
                    end else begin
                        cnt++;
                    end
                end else if (phase == 0 && arvalid) begin
                    if (cnt >= ar_delay) begin
                        arready = 1'b1;
                        a = araddr;
                        phase = 1;
                        cnt = 0;
                        chk("ar_expected", {31'b0, exp_addr.size() != 0}, 32'd1);
                        if (exp_addr.size() != 0) chk("araddr", araddr, exp_addr.pop_front());
                    end else begin
                        cnt++;
                    end
                end
            end
        end
    end

    // Decode-side monitor: every accepted beat is popped and compared.
    initial begin
        exp_t x;
        forever begin
            @(negedge clock);
            if (reset && valid_next && ready_next) begin
                n_out++;
                chk("out_expected", {31'b0, exp_out.size() != 0}, 32'd1);
                if (exp_out.size() != 0) begin
                    x = exp_out.pop_front();
                    chk("inst", inst, x.inst);
                    chk("pc", pc, x.pc);
                    chk("fetch_err", {31'b0, fetch_err}, {31'b0, x.err});
                end
            end
        end
    end

    initial begin
        reset = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        ready_next = 1'b1;
        repeat (2) step();
        chk("rst_arvalid", {31'b0, arvalid}, 32'd0);
        chk("rst_rready", {31'b0, rready}, 32'd0);
        chk("rst_valid", {31'b0, valid_next}, 32'd0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_err", {31'b0, fetch_err}, 32'd0);
        chk("rst_araddr", araddr, 32'h8000_0000);

        // Streaming fetches, then stall with 0x8000000C parked in OUT.
        exp_addr.push_back(32'h8000_0000);
        exp_addr.push_back(32'h8000_0004);
        exp_addr.push_back(32'h8000_0008);
        exp_addr.push_back(32'h8000_000C);
        push_out(32'h8000_0000, 1'b0);
        push_out(32'h8000_0004, 1'b0);
        push_out(32'h8000_0008, 1'b0);
        reset = 1'b1;
        wait_nout(3, "t1_three_beats");
        ready_next = 1'b0;

        // Back-pressure: beat held, no new fetch.
        wait_valid("t2_wait_valid");
        for (int i = 0; i < 5; i++) begin
            chk("t2_hold_inst", inst, mem_word(32'h8000_000C));
            chk("t2_hold_pc", pc, 32'h8000_000C);
            chk("t2_no_fetch", {31'b0, arvalid}, 32'd0);
            step();
        end
        push_out(32'h8000_000C, 1'b0);
        push_out(32'h8000_0010, 1'b1);
        exp_addr.push_back(32'h8000_0010);
        exp_addr.push_back(32'h8000_0014);
        ready_next = 1'b1;
        wait_nout(5, "t2_t4_release");
        ready_next = 1'b0;

        // Redirect together with acceptance in OUT.
        wait_valid("t5_wait_valid");
        push_out(32'h8000_0014, 1'b0);
        exp_addr.push_back(32'h8000_2000);
        ready_next = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h8000_2000;
        step();
        ready_next = 1'b0;
        redirect_valid = 1'b0;
        chk("t5_consumed_once", n_out, 32'd6);

        // Redirect while DATA waits on a late response.
        wait_valid("t3_wait_valid");
        push_out(32'h8000_2000, 1'b0);
        exp_addr.push_back(32'h8000_2004);
        exp_addr.push_back(32'h8000_1000);
        r_delay = 3;
        ready_next = 1'b1;
        wait_nout(7, "t3_consume");
        ready_next = 1'b0;
        wait_rready("t3_wait_data");
        redirect_valid = 1'b1;
        redirect_pc = 32'h8000_1002;
        step();
        redirect_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            chk("t3_no_valid", {31'b0, valid_next}, 32'd0);
            if (arvalid) break;
            step();
        end
        r_delay = 0;
        wait_valid("t3_redir_valid");
        push_out(32'h8000_1000, 1'b0);
        exp_addr.push_back(32'h8000_1004);
        ready_next = 1'b1;
        wait_nout(8, "t3_release");
        ready_next = 1'b0;

        // Redirect in OUT without acceptance drops the beat; PC wraps.
        wait_valid("wrap_wait_valid");
        exp_addr.push_back(32'hFFFF_FFFC);
        exp_addr.push_back(32'h0000_0000);
        exp_addr.push_back(32'h0000_0004);
        push_out(32'hFFFF_FFFC, 1'b0);
        push_out(32'h0000_0000, 1'b0);
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFE;
        step();
        redirect_valid = 1'b0;
        chk("wrap_dropped", {31'b0, valid_next}, 32'd0);
        ready_next = 1'b1;
        wait_nout(10, "wrap_release");
        ready_next = 1'b0;

        // Reset while a fetch is waiting in DATA.
        wait_valid("t6_wait_valid");
        push_out(32'h0000_0004, 1'b0);
        exp_addr.push_back(32'h0000_0008);
        r_delay = 3;
        ready_next = 1'b1;
        wait_nout(11, "t6_consume");
        ready_next = 1'b0;
        wait_rready("t6_wait_data");
        reset = 1'b0;
        #1;
        chk("t6_arvalid", {31'b0, arvalid}, 32'd0);
        chk("t6_rready", {31'b0, rready}, 32'd0);
        chk("t6_valid", {31'b0, valid_next}, 32'd0);
        chk("t6_inst", inst, 32'h0);
        chk("t6_pc", pc, 32'h0);
        chk("t6_err", {31'b0, fetch_err}, 32'd0);
        repeat (3) step();
        r_delay = 0;
        exp_addr.push_back(32'h8000_0000);
        exp_addr.push_back(32'h8000_0004);
        push_out(32'h8000_0000, 1'b0);
        ready_next = 1'b1;
        reset = 1'b1;
        wait_nout(12, "t6_after_reset");
        ready_next = 1'b0;
        repeat (10) step();
        chk("addr_queue_empty", exp_addr.size(), 32'd0);
        chk("out_queue_empty", exp_out.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
